// File: rtl/fm_sb_pkg.sv
// fm_sb_pkg: shared widths and types for the felix-monitor spy-buffer blocks
// Supplies default record/bus widths, the playback mode encoding and the playback FSM states.
package fm_sb_pkg;
  localparam int mon_dw_max = 256;
  localparam int axi_dw = 32;
  localparam int pb_mode_width = 2;
  typedef enum logic [pb_mode_width-1:0] {PB_OFF, PB_SINGLE, PB_LOOP, PB_RSVD} pb_mode_t;
  typedef enum logic [1:0] {IDLE, PLAY, GAP} pb_state_t;
endpackage

// File: rtl/fm_sb_playback_if.sv
// fm_sb_playback_if: control-bus word access to the playback RAM
// master drives enable/write/address/data, slave returns the registered read word.
interface fm_sb_playback_if import fm_sb_pkg::*; #(parameter int AXI_DW = axi_dw);
  logic axi_enable;
  logic axi_wr_enable;
  logic [15:0] axi_addr;
  logic [AXI_DW-1:0] axi_wr_data;
  logic [AXI_DW-1:0] axi_rd_data;
  modport master(output axi_enable, axi_wr_enable, axi_addr, axi_wr_data, input axi_rd_data);
  modport slave(input axi_enable, axi_wr_enable, axi_addr, axi_wr_data, output axi_rd_data);
endinterface

// File: rtl/fm_sb_pb_mem.sv
// fm_sb_pb_mem: record RAM with a lane-wide bus port and a record-wide playback port
// Ports: clk/rst; a_* lane write + registered lane read (0 when out of range);
// b_en/b_addr/b_rdata registered full-record read, read-first against port A writes.
module fm_sb_pb_mem import fm_sb_pkg::*; #(
  parameter int MON_DW = mon_dw_max,
  parameter int AXI_DW = axi_dw,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_en,
  input  logic              a_we,
  input  logic [15:0]       a_addr,
  input  logic [AXI_DW-1:0] a_wdata,
  output logic [AXI_DW-1:0] a_rdata,
  input  logic              b_en,
  input  logic [ADDR_W-1:0] b_addr,
  output logic [MON_DW-1:0] b_rdata
);
  localparam int nl = MON_DW / AXI_DW;
  localparam int lw = $clog2(nl);
  logic [nl-1:0][AXI_DW-1:0] ram [2**ADDR_W];
  logic [ADDR_W-1:0] a_rec;
  logic [lw-1:0] a_lane;
  logic a_hit;
  logic [AXI_DW-1:0] a_rdata_q;
  logic [MON_DW-1:0] b_rdata_q;
  always_comb begin
    a_rec = a_addr[lw +: ADDR_W];
    a_lane = a_addr[lw-1:0];
    a_hit = (a_addr >> (lw + ADDR_W)) == '0;
  end
  // Nonblocking RAM update makes port B see the pre-write record on a collision.
  always_ff @(posedge clk) begin
    if (a_en & a_we & a_hit) ram[a_rec][a_lane] <= a_wdata;
    if (b_en) b_rdata_q <= ram[b_addr];
    if (rst) a_rdata_q <= '0;
    else if (a_en & ~a_we) a_rdata_q <= a_hit ? ram[a_rec][a_lane] : '0;
  end
  assign a_rdata = a_rdata_q;
  assign b_rdata = b_rdata_q;
endmodule

// File: rtl/fm_sb_playback.sv
// fm_sb_playback: replays bus-written records as an fm_data/fm_vld stream
// Ports: clk/rst; bus (control-bus RAM access); pb_mode/pb_start/pb_stop/pb_len/pb_gap
// playback control; fm_data/fm_vld record stream; pb_busy activity; pb_done sticky completion.
module fm_sb_playback import fm_sb_pkg::*; #(
  parameter int MON_DW = mon_dw_max,
  parameter int AXI_DW = axi_dw,
  parameter int ADDR_W = 6,
  parameter int GAP_W = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  fm_sb_playback_if.slave          bus,
  input  logic [pb_mode_width-1:0] pb_mode,
  input  logic                     pb_start,
  input  logic                     pb_stop,
  input  logic [ADDR_W:0]          pb_len,
  input  logic [GAP_W-1:0]         pb_gap,
  output logic [MON_DW-1:0]        fm_data,
  output logic                     fm_vld,
  output logic                     pb_busy,
  output logic                     pb_done
);
  localparam logic [ADDR_W:0] depth = (ADDR_W+1)'(2**ADDR_W);
  pb_state_t state_q, state_d;
  pb_mode_t mode;
  logic [ADDR_W:0] ptr_q, ptr_d, len_q, len_d, len_c, ptr_nx;
  logic [GAP_W-1:0] gap_q, gap_d, gcnt_q, gcnt_d;
  logic single_q, single_d, vld_q, vld_d, done_q, done_d, last_q, last_d;
  logic stop_c, start_c, wrap;
  logic [MON_DW-1:0] rec;
  fm_sb_pb_mem #(.MON_DW(MON_DW), .AXI_DW(AXI_DW), .ADDR_W(ADDR_W)) u_mem (
    .clk(clk), .rst(rst),
    .a_en(bus.axi_enable), .a_we(bus.axi_wr_enable), .a_addr(bus.axi_addr),
    .a_wdata(bus.axi_wr_data), .a_rdata(bus.axi_rd_data),
    .b_en(state_q == PLAY), .b_addr(ptr_q[ADDR_W-1:0]), .b_rdata(rec)
  );
  // Busy also covers the cycle the last record is on the stream after the FSM is back in IDLE.
  assign pb_busy = (state_q != IDLE) | vld_q;
  assign fm_vld = vld_q;
  assign fm_data = vld_q ? rec : '0;
  assign pb_done = done_q;
  always_comb begin
    mode = pb_mode_t'(pb_mode);
    stop_c = pb_stop | ~(mode == PB_SINGLE || mode == PB_LOOP);
    len_c = (pb_len > depth) ? depth : pb_len;
    start_c = pb_start & ~stop_c & ~pb_busy & (len_c != '0);
    ptr_nx = ptr_q + 1'b1;
    wrap = ptr_nx == len_q;
    state_d = state_q;
    ptr_d = ptr_q;
    len_d = len_q;
    gap_d = gap_q;
    gcnt_d = gcnt_q;
    single_d = single_q;
    vld_d = 1'b0;
    last_d = 1'b0;
    done_d = done_q | (last_q & ~stop_c);
    if (stop_c) state_d = IDLE;
    else if (state_q == IDLE) begin
      if (start_c) begin
        state_d = PLAY;
        ptr_d = '0;
        len_d = len_c;
        gap_d = pb_gap;
        single_d = mode == PB_SINGLE;
        done_d = 1'b0;
      end
    end else if (state_q == PLAY) begin
      vld_d = 1'b1;
      ptr_d = wrap ? '0 : ptr_nx;
      // Completion is tested before the gap so a single shot ends without a trailing gap.
      if (single_q & wrap) begin
        state_d = IDLE;
        last_d = 1'b1;
      end else if (gap_q != '0) begin
        state_d = GAP;
        gcnt_d = gap_q;
      end
    end else begin
      state_d = (gcnt_q == 1) ? PLAY : GAP;
      gcnt_d = gcnt_q - 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q <= '0;
      len_q <= '0;
      gap_q <= '0;
      gcnt_q <= '0;
      single_q <= 1'b0;
      vld_q <= 1'b0;
      done_q <= 1'b0;
      last_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      len_q <= len_d;
      gap_q <= gap_d;
      gcnt_q <= gcnt_d;
      single_q <= single_d;
      vld_q <= vld_d;
      done_q <= done_d;
      last_q <= last_d;
    end
  end
endmodule

// File: tb/tb_fm_sb_playback.sv
// tb_fm_sb_playback: directed self-checking bench for fm_sb_playback
module tb_fm_sb_playback;
  import fm_sb_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] pb_mode = 2'd0;
  logic pb_start = 1'b0;
  logic pb_stop = 1'b0;
  logic [6:0] pb_len = '0;
  logic [3:0] pb_gap = '0;
  logic [255:0] fm_data;
  logic fm_vld, pb_busy, pb_done;
  logic [255:0] model [64];
  logic [31:0] rd;
  int checks = 0;
  int failures = 0;
  fm_sb_playback_if #(.AXI_DW(32)) bus();
  fm_sb_playback #(.MON_DW(256), .AXI_DW(32), .ADDR_W(6), .GAP_W(4)) dut (
    .clk(clk), .rst(rst), .bus(bus), .pb_mode(pb_mode), .pb_start(pb_start),
    .pb_stop(pb_stop), .pb_len(pb_len), .pb_gap(pb_gap), .fm_data(fm_data),
    .fm_vld(fm_vld), .pb_busy(pb_busy), .pb_done(pb_done)
  );
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [31:0] d);
    bus.axi_enable = 1'b1;
    bus.axi_wr_enable = 1'b1;
    bus.axi_addr = a;
    bus.axi_wr_data = d;
    tick;
    bus.axi_enable = 1'b0;
    bus.axi_wr_enable = 1'b0;
    if (a < 16'd512) model[a[8:3]][32*a[2:0] +: 32] = d;
  endtask

  task automatic bus_read(input logic [15:0] a, output logic [31:0] d);
    bus.axi_enable = 1'b1;
    bus.axi_wr_enable = 1'b0;
    bus.axi_addr = a;
    tick;
    bus.axi_enable = 1'b0;
    d = bus.axi_rd_data;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick;
    tick;
    checks++;
    if ({fm_vld, pb_busy, pb_done} !== 3'b000) begin
      failures++;
      $display("FAIL reset_flags vld/busy/done=%b expected 000", {fm_vld, pb_busy, pb_done});
    end
    checks++;
    if (fm_data !== '0) begin
      failures++;
      $display("FAIL reset_data fm_data=%h expected 0", fm_data);
    end
    checks++;
    if (bus.axi_rd_data !== 32'd0) begin
      failures++;
      $display("FAIL reset_rd axi_rd_data=%h expected 0", bus.axi_rd_data);
    end
    rst = 1'b0;
    tick;
  endtask

  task automatic test_bus;
    for (int l = 0; l < 8; l++) bus_write(16'(24 + l), 32'(8'h30 + l));
    bus_read(16'd29, rd);
    checks++;
    if (rd !== 32'h35) begin failures++; $display("FAIL bus_rd_lane5 got %h expected 00000035", rd); end
    bus_read(16'd24, rd);
    checks++;
    if (rd !== 32'h30) begin failures++; $display("FAIL bus_rd_lane0 got %h expected 00000030", rd); end
    bus_read(16'd31, rd);
    tick;
    checks++;
    if (bus.axi_rd_data !== 32'h37) begin
      failures++;
      $display("FAIL bus_rd_hold got %h expected 00000037", bus.axi_rd_data);
    end
    bus_read(16'd512, rd);
    checks++;
    if (rd !== 32'h0) begin failures++; $display("FAIL bus_rd_oor got %h expected 0", rd); end
    for (int r = 0; r < 4; r++)
      for (int l = 0; l < 8; l++) bus_write(16'(r*8 + l), 32'hAB00_0000 | 32'(r << 8) | 32'(l));
    bus_write(16'd512, 32'hDEAD_BEEF);
    bus_read(16'd0, rd);
    checks++;
    if (rd !== 32'hAB00_0000) begin failures++; $display("FAIL bus_wr_oor_alias got %h expected ab000000", rd); end
  endtask

  task automatic test_single;
    logic [2:0] ef;
    logic [255:0] ed;
    pb_mode = 2'd1; pb_len = 7'd4; pb_gap = 4'd0; pb_start = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      tick;
      pb_start = 1'b0;
      ef = {c >= 2 && c <= 5, c <= 5, c == 6};
      ed = ef[2] ? model[c-2] : '0;
      checks++;
      if ({fm_vld, pb_busy, pb_done} !== ef) begin
        failures++;
        $display("FAIL single_flags c=%0d vld/busy/done=%b expected %b", c, {fm_vld, pb_busy, pb_done}, ef);
      end
      checks++;
      if (fm_data !== ed) begin
        failures++;
        $display("FAIL single_data c=%0d fm_data=%h expected %h", c, fm_data, ed);
      end
    end
  endtask

  task automatic test_loop_gap;
    logic [2:0] ef;
    logic [255:0] ed;
    pb_mode = 2'd2; pb_len = 7'd2; pb_gap = 4'd2; pb_start = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      tick;
      pb_start = 1'b0;
      if (c == 3) begin pb_len = 7'd4; pb_gap = 4'd0; end
      pb_stop = c == 13;
      ef = {c == 2 || c == 5 || c == 8 || c == 11, c <= 13, 1'b0};
      ed = ef[2] ? model[((c-2)/3) % 2] : '0;
      checks++;
      if ({fm_vld, pb_busy, pb_done} !== ef) begin
        failures++;
        $display("FAIL loop_flags c=%0d vld/busy/done=%b expected %b", c, {fm_vld, pb_busy, pb_done}, ef);
      end
      checks++;
      if (fm_data !== ed) begin
        failures++;
        $display("FAIL loop_data c=%0d fm_data=%h expected %h", c, fm_data, ed);
      end
    end
    pb_stop = 1'b0;
  endtask

  task automatic test_rejected;
    for (int a = 0; a < 3; a++) begin
      pb_mode = (a == 0) ? 2'd2 : (a == 1) ? 2'd3 : 2'd1;
      pb_len = (a == 0) ? 7'd0 : 7'd2;
      pb_stop = a == 2;
      pb_start = 1'b1;
      for (int c = 1; c <= 4; c++) begin
        tick;
        pb_start = 1'b0;
        pb_stop = 1'b0;
        checks++;
        if ({fm_vld, pb_busy, pb_done} !== 3'b000 || fm_data !== '0) begin
          failures++;
          $display("FAIL reject a=%0d c=%0d vld/busy/done=%b data=%h expected 000 and 0", a, c,
                   {fm_vld, pb_busy, pb_done}, fm_data);
        end
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [2:0] tbl [9] = '{3'b010, 3'b110, 3'b110, 3'b110, 3'b110, 3'b001, 3'b010, 3'b110, 3'b001};
    logic [255:0] ed;
    pb_mode = 2'd1; pb_len = 7'd4; pb_gap = 4'd0; pb_start = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      tick;
      pb_start = c == 3 || c == 5 || c == 6;
      if (c == 3) begin pb_mode = 2'd2; pb_len = 7'd1; end
      if (c == 6) pb_mode = 2'd1;
      ed = (c >= 2 && c <= 5) ? model[c-2] : (c == 8) ? model[0] : '0;
      checks++;
      if ({fm_vld, pb_busy, pb_done} !== tbl[c-1]) begin
        failures++;
        $display("FAIL b2b_flags c=%0d vld/busy/done=%b expected %b", c, {fm_vld, pb_busy, pb_done}, tbl[c-1]);
      end
      checks++;
      if (fm_data !== ed) begin
        failures++;
        $display("FAIL b2b_data c=%0d fm_data=%h expected %h", c, fm_data, ed);
      end
    end
    pb_start = 1'b0;
  endtask

  task automatic test_collision;
    logic [255:0] old1, new1, ed;
    logic [2:0] ef;
    old1 = model[1];
    new1 = old1;
    new1[31:0] = 32'h5A5A_5A5A;
    pb_mode = 2'd2; pb_len = 7'd2; pb_gap = 4'd0; pb_start = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      tick;
      pb_start = 1'b0;
      bus.axi_enable = c == 2;
      bus.axi_wr_enable = c == 2;
      bus.axi_addr = 16'd8;
      bus.axi_wr_data = 32'h5A5A_5A5A;
      pb_stop = c == 5;
      ef = {c >= 2 && c <= 5, c <= 5, 1'b0};
      ed = (c == 2 || c == 4) ? model[0] : (c == 3) ? old1 : (c == 5) ? new1 : '0;
      checks++;
      if ({fm_vld, pb_busy, pb_done} !== ef) begin
        failures++;
        $display("FAIL coll_flags c=%0d vld/busy/done=%b expected %b", c, {fm_vld, pb_busy, pb_done}, ef);
      end
      checks++;
      if (fm_data !== ed) begin
        failures++;
        $display("FAIL coll_data c=%0d fm_data=%h expected %h", c, fm_data, ed);
      end
    end
    pb_stop = 1'b0;
    model[1] = new1;
  endtask

  task automatic test_reset_mid;
    logic [2:0] ef;
    logic [255:0] ed;
    pb_mode = 2'd2; pb_len = 7'd3; pb_gap = 4'd0; pb_start = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      tick;
      pb_start = 1'b0;
    end
    rst = 1'b1;
    tick;
    rst = 1'b0;
    checks++;
    if ({fm_vld, pb_busy, pb_done} !== 3'b000 || fm_data !== '0 || bus.axi_rd_data !== 32'd0) begin
      failures++;
      $display("FAIL rst_mid vld/busy/done=%b data=%h rd=%h expected 000, 0, 0",
               {fm_vld, pb_busy, pb_done}, fm_data, bus.axi_rd_data);
    end
    pb_mode = 2'd1; pb_start = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      tick;
      pb_start = 1'b0;
      ef = {c >= 2 && c <= 4, c <= 4, c == 5};
      ed = ef[2] ? model[c-2] : '0;
      checks++;
      if ({fm_vld, pb_busy, pb_done} !== ef || fm_data !== ed) begin
        failures++;
        $display("FAIL replay c=%0d vld/busy/done=%b data=%h expected %b data %h", c,
                 {fm_vld, pb_busy, pb_done}, fm_data, ef, ed);
      end
    end
  endtask

  task automatic test_len_clamp;
    int done_c;
    done_c = -1;
    pb_mode = 2'd1; pb_len = 7'd127; pb_gap = 4'd0; pb_start = 1'b1;
    for (int c = 1; c <= 80; c++) begin
      tick;
      pb_start = 1'b0;
      if (pb_done && done_c < 0) done_c = c;
    end
    checks++;
    if (done_c != 66) begin
      failures++;
      $display("FAIL len_clamp done first seen at cycle %0d expected 66", done_c);
    end
  endtask

  initial begin
    bus.axi_enable = 1'b0;
    bus.axi_wr_enable = 1'b0;
    bus.axi_addr = '0;
    bus.axi_wr_data = '0;
    test_reset;
    test_bus;
    test_single;
    test_loop_gap;
    test_rejected;
    test_back_to_back;
    test_collision;
    test_reset_mid;
    test_len_clamp;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fm_sb_playback.md
# fm_sb_playback

Playback buffer for the felix-monitor spy path: the control bus writes 256-bit records into a local RAM in 32-bit words, then the block replays them into the user datapath as an `fm_rt`-style stream (`fm_data`/`fm_vld`). It is the transmit-side counterpart of the spy buffer, which captures `fm_data`/`fm_vld` for readout. One instance sits per spy-buffer slot, next to the matching capture buffer.

## Interface

- `MON_DW`, 256: record width; must be a multiple of `AXI_DW`.
- `AXI_DW`, 32: control-bus data width.
- `ADDR_W`, 6: log2 of record depth (64 records); requires `ADDR_W + $clog2(MON_DW/AXI_DW) <= 16`.
- `GAP_W`, 4: width of the inter-record gap count.
- Clock and reset: one clock; reset is synchronous and active-high. Ports are named `clk` and `rst`.
- `clk` in 1: single clock for the bus side and the stream side.
- `rst` in 1: synchronous, active-high.
- `axi_enable` in 1: bus access strobe.
- `axi_wr_enable` in 1: write when high, read when low.
- `axi_addr` in 16: word address; `{record, lane}` with lane = low `$clog2(MON_DW/AXI_DW)` bits.
- `axi_wr_data` in `AXI_DW`: write word.
- `axi_rd_data` out `AXI_DW`: read word, registered.
- `pb_mode` in 2: `00` off, `01` single-shot, `10` loop, `11` reserved (treated as off).
- `pb_start` in 1: start pulse.
- `pb_stop` in 1: stop pulse.
- `pb_len` in `ADDR_W+1`: number of records to play; clamped to `2**ADDR_W`.
- `pb_gap` in `GAP_W`: idle cycles inserted between records.
- `fm_data` out `MON_DW`: playback record; zero whenever `fm_vld` is low.
- `fm_vld` out 1: record valid.
- `pb_busy` out 1: playback active.
- `pb_done` out 1: sticky single-shot completion; cleared by the next accepted start.

## Operation

- **Bus write.** When `axi_enable & axi_wr_enable`, the addressed lane of the addressed record is written. Other lanes are untouched. Writes outside the RAM depth are dropped.
- **Bus read.** When `axi_enable & ~axi_wr_enable`, `axi_rd_data` shows the lane on the next cycle. Out-of-range reads return 0. Otherwise `axi_rd_data` holds its value.
- **FSM states:** `IDLE`, `PLAY`, `GAP`.
- **IDLE → PLAY.** Taken on `pb_start` when `pb_mode` is `01` or `10`, the clamped length is nonzero, and `pb_stop` is low. This clears `pb_done`, sets the read pointer to 0 and raises `pb_busy`.
- **Start ignored** when the mode is off/reserved, `pb_len` is 0, or the block is already busy.
- **PLAY.** Issues a read of the current record and advances the pointer.
  - If `pb_gap` is nonzero, go to `GAP` and load the gap counter.
  - If the pointer reaches `len` in single-shot mode, return to `IDLE` and set `pb_done`.
  - In loop mode the pointer wraps to 0.
- **GAP.** Counts down `pb_gap` cycles, then returns to `PLAY`. Single-shot completion is checked before entering `GAP`, so no trailing gap occurs.
- **Stop.** `pb_stop` in any state, or `pb_mode` going to off, forces `IDLE`. The in-flight record is dropped and `pb_done` is not set.
- **Concurrency.** `pb_start` and `pb_stop` in the same cycle: stop wins. `pb_len`, `pb_gap` and mode (`01` vs `10`) are latched at start; later changes take effect at the next start.
- **Writes during playback** are allowed. A same-cycle write and playback read of the same record returns the old data (read-first).
- **Reset.** `fm_data=0`, `fm_vld=0`, `pb_busy=0`, `pb_done=0`, `axi_rd_data=0`, FSM `IDLE`. RAM contents are not reset.

## Timing

- `pb_start` accepted in cycle T:
  - record k is on `fm_vld`/`fm_data` in cycle T+2+k·(`pb_gap`+1);
  - `pb_busy` is high from T+1.
- Single-shot, last record in cycle L: `pb_busy` falls and `pb_done` rises in cycle L+1.
- Stop in cycle S: `fm_vld=0` and `pb_busy=0` from S+1.
- A new start is accepted in the first cycle `pb_busy` is low.
- Bus read latency: 1 cycle. Back-to-back accesses run every cycle.

## Structure

- `fm_sb_pkg` gains:
  - the `pb_mode_t` enum (`PB_OFF`, `PB_SINGLE`, `PB_LOOP`, `PB_RSVD`, width `pb_mode_width`);
  - the `pb_state_t` FSM typedef.
- `fm_sb_pkg` already supplies `mon_dw_max`/`axi_dw`, which serve as the `MON_DW`/`AXI_DW` defaults.
- Sub-module `fm_sb_pb_mem`:
  - port A: lane-write plus registered lane-read for the bus;
  - port B: registered full-record read for playback, read-first.
- FSM, counters and output register live in `fm_sb_playback`.

## Test plan

- **Bus write/read.** Write 8 lanes of record 3 with `0x30..0x37`, read lane 5 → `axi_rd_data=0x35` one cycle after the read strobe. Read address 512 → 0.
- **Single-shot.** `pb_len=4`, `pb_gap=0`, start at T → `fm_vld` in T+2..T+5 with records 0..3; `pb_done=1` and `pb_busy=0` at T+6.
- **Loop with gap.** `pb_len=2`, `pb_gap=2` → records 0,1,0,1,… every 3 cycles. `pb_stop` at S → `fm_vld=0` from S+1, `pb_done` stays 0.
- **Rejected starts.** `pb_len=0`, mode `11`, start while busy, and start+stop in the same cycle → no `fm_vld`, no state change.
- **Read-first collision.** Overwrite record 1 in the cycle it is read for playback → old value emitted; next loop pass emits the new value.
- **Reset mid-playback.** `rst` asserted in loop mode → next cycle all outputs 0, FSM `IDLE`. A fresh start replays the RAM unchanged.
